spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the SPI word width in bits.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving the SCK half-period in clk cycles (legal range >=1).
REQ-003 clk  input  1  system clock; one clock domain, all logic updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  permits new transfers to start.
REQ-006 tx_fifo_empty  input  1  TX FIFO has no word available.
REQ-007 tx_fifo_dout  input  DATA_W  TX FIFO read data, valid the cycle after tx_fifo_rd.
REQ-008 tx_fifo_rd  output  1  TX FIFO read strobe, single-cycle pulse.
REQ-009 rx_fifo_full  input  1  RX FIFO cannot accept a word.
REQ-010 rx_fifo_din  output  DATA_W  received word.
REQ-011 rx_fifo_wr  output  1  RX FIFO write strobe, single-cycle pulse.
REQ-012 spi_sck, spi_mosi, spi_cs_n  output  1 each  SPI mode 0 master pins; spi_miso  input  1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 rx_overflow  output  1  sticky flag: a received word was dropped.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, SHIFT, STORE, HOLD.
REQ-016 IDLE: spi_cs_n=1, spi_sck=0; if enable=1 and tx_fifo_empty=0, pulse tx_fifo_rd for exactly one cycle and go to FETCH.
REQ-017 FETCH: wait one cycle; go to LOAD.
REQ-018 LOAD: capture tx_fifo_dout into the shift register, drive spi_cs_n=0, clear bit counter and divider, go to SHIFT.
REQ-019 SHIFT: per bit, spi_sck low for CLK_DIV cycles, then high for CLK_DIV cycles; MSB first.
REQ-020 spi_mosi SHALL present the current MSB of the shift register throughout each bit's low phase and high phase.
REQ-021 spi_miso SHALL be sampled into the receive register LSB on the clk edge at which spi_sck goes 0->1.
REQ-022 The shift register SHALL shift left one bit on each spi_sck 1->0 transition.
REQ-023 A word SHALL occupy exactly DATA_W*2*CLK_DIV clk cycles in SHIFT; after the last high phase spi_sck returns to 0 and the FSM goes to STORE.
REQ-024 STORE, rx_fifo_full=0: present received word on rx_fifo_din and pulse rx_fifo_wr for one cycle.
REQ-025 STORE, rx_fifo_full=1: no write; set rx_overflow=1; the word is discarded.
REQ-026 STORE, enable=1 and tx_fifo_empty=0: pulse tx_fifo_rd and go to FETCH with spi_cs_n held low (back-to-back burst). Otherwise go to HOLD.
REQ-027 HOLD: spi_cs_n stays 0 and spi_sck stays 0 for CLK_DIV cycles, then spi_cs_n=1 and the FSM goes to IDLE.
REQ-028 enable deasserted during FETCH/LOAD/SHIFT SHALL NOT abort; the current word completes and the FSM exits via HOLD.
REQ-029 tx_fifo_rd SHALL never be asserted while tx_fifo_empty=1; rx_fifo_wr SHALL never be asserted while rx_fifo_full=1.
REQ-030 rx_overflow SHALL clear only on rst.
REQ-031 Divider and bit counter SHALL be sized ceil(log2(CLK_DIV+1)) and ceil(log2(DATA_W+1)) bits; no wrap-around within a word.

Reset
REQ-032 While rst=1 the next edge SHALL force: state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, tx_fifo_rd=0, rx_fifo_wr=0, rx_fifo_din=0, busy=0, rx_overflow=0.
REQ-033 rst during any state SHALL abort the transfer with no rx_fifo_wr and no further tx_fifo_rd; the partial word is lost.

Verification
REQ-034 DATA_W=8, CLK_DIV=2, TX holds 0xA5, miso looped to mosi -> one tx_fifo_rd, 8 SCK pulses each 2 cycles high, rx_fifo_wr once with 0xA5, cs_n low from LOAD until 2 cycles after STORE.
REQ-035 TX holds 0x3C, 0xC3, enable=1 -> cs_n stays low across both words, two rx writes 0x3C then 0xC3, exactly two tx_fifo_rd pulses.
REQ-036 rx_fifo_full=1 during STORE, miso=1 -> no rx_fifo_wr, rx_overflow=1 and remains 1 after a further successful word.
REQ-037 enable dropped after 3 SCK pulses with 2 words queued -> first word completes (8 pulses), no second tx_fifo_rd, cs_n high 2 cycles after STORE.
REQ-038 rst asserted at 4th SCK pulse -> next edge cs_n=1, sck=0, busy=0, no rx_fifo_wr; after release with TX non-empty a new transfer starts normally.
REQ-039 tx_fifo_empty=1, enable=1 for 50 cycles -> tx_fifo_rd never asserted, busy=0, cs_n=1.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI mode 0 master that moves words from a TX FIFO to the wire and stores the
// words clocked in on MISO into an RX FIFO, with back-to-back bursts under one CS.
module spi_xfer_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tx_fifo_empty,
    input  logic [DATA_W-1:0] tx_fifo_dout,
    output logic              tx_fifo_rd,
    input  logic              rx_fifo_full,
    output logic [DATA_W-1:0] rx_fifo_din,
    output logic              rx_fifo_wr,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    input  logic              spi_miso,
    output logic              busy,
    output logic              rx_overflow
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, STORE, HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rxreg;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  cnt;
    logic              start_ok;

    assign start_ok = enable & ~tx_fifo_empty;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            rxreg       <= '0;
            div         <= '0;
            cnt         <= '0;
            tx_fifo_rd  <= 1'b0;
            rx_fifo_wr  <= 1'b0;
            rx_fifo_din <= '0;
            spi_sck     <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_cs_n    <= 1'b1;
            rx_overflow <= 1'b0;
        end else begin
            tx_fifo_rd <= 1'b0;
            rx_fifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs_n <= 1'b1;
                    spi_sck  <= 1'b0;
                    if (start_ok) begin
                        tx_fifo_rd <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // Assert CS on entry to LOAD so it is already low there.
                    spi_cs_n <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: begin
                    shreg    <= tx_fifo_dout;
                    spi_mosi <= tx_fifo_dout[DATA_W-1];
                    div      <= '0;
                    cnt      <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rxreg   <= {rxreg[DATA_W-2:0], spi_miso};
                        end else begin
                            spi_sck  <= 1'b0;
                            shreg    <= {shreg[DATA_W-2:0], 1'b0};
                            spi_mosi <= shreg[DATA_W-2];
                            cnt      <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                state <= STORE;
                            end
                        end
                    end
                end
                STORE: begin
                    if (!rx_fifo_full) begin
                        rx_fifo_wr  <= 1'b1;
                        rx_fifo_din <= rxreg;
                    end else begin
                        rx_overflow <= 1'b1;
                    end
                    div <= '0;
                    if (start_ok) begin
                        tx_fifo_rd <= 1'b1;
                        state      <= FETCH;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (div == DIV_LAST) begin
                        spi_cs_n <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomised scoreboard bench for spi_xfer_ctrl: a FIFO model feeds words, a pin-level
// monitor rebuilds MOSI/MISO words and a separate RX monitor checks the stored words.
module tb_spi_xfer_ctrl;

    localparam int W   = 8;
    localparam int DIV = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         tx_fifo_empty = 1'b1;
    logic [W-1:0] tx_fifo_dout = '0;
    logic         tx_fifo_rd;
    logic         rx_fifo_full = 1'b0;
    logic [W-1:0] rx_fifo_din;
    logic         rx_fifo_wr;
    logic         spi_sck, spi_mosi, spi_cs_n, spi_miso;
    logic         busy, rx_overflow;

    int           miso_mode = 0;  // 0 loopback, 1 constant one, 2 random
    logic         miso_rand = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] txq[$];
    logic [W-1:0] exp_tx[$];
    logic [W-1:0] exp_rx[$];
    logic         exp_ovf = 1'b0;

    int rd_count = 0;
    int wr_count = 0;
    int pulses_total = 0;
    int last_win = 0;

    assign spi_miso = (miso_mode == 0) ? spi_mosi : (miso_mode == 1) ? 1'b1 : miso_rand;

    spi_xfer_ctrl #(.DATA_W(W), .CLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_dout (tx_fifo_dout),
        .tx_fifo_rd   (tx_fifo_rd),
        .rx_fifo_full (rx_fifo_full),
        .rx_fifo_din  (rx_fifo_din),
        .rx_fifo_wr   (rx_fifo_wr),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .busy         (busy),
        .rx_overflow  (rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX FIFO model: a strobe seen in cycle N delivers data during cycle N+1.
    initial begin
        logic rd_seen;
        forever begin
            @(negedge clk);
            rd_seen = tx_fifo_rd;
            if (rd_seen) rd_count++;
            @(posedge clk);
            #1;
            if (rd_seen) begin
                if (txq.size() == 0) begin
                    check("rd_while_empty", 1, 0);
                end else begin
                    tx_fifo_dout = txq.pop_front();
                    exp_tx.push_back(tx_fifo_dout);
                end
            end
            tx_fifo_empty = (txq.size() == 0);
        end
    end

    // Pin monitor: rebuilds words at SCK rising edges and checks phase lengths.
    initial begin
        logic         sck_prev = 1'b0;
        logic         cs_prev  = 1'b1;
        int           run = 0;
        int           since_fall = 0;
        int           bitcnt = 0;
        int           win = 0;
        logic [W-1:0] mo = '0;
        logic [W-1:0] mi = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sck_prev = 1'b0; cs_prev = 1'b1; run = 0; since_fall = 0;
                bitcnt = 0; win = 0;
            end else begin
                if (spi_sck && !sck_prev) begin
                    if (bitcnt > 0) check("sck_low_len", run, DIV);
                    run = 1;
                    since_fall++;
                    mo = {mo[W-2:0], spi_mosi};
                    mi = {mi[W-2:0], spi_miso};
                    bitcnt++; win++; pulses_total++;
                    if (bitcnt == W) begin
                        bitcnt = 0;
                        if (exp_tx.size() == 0) check("mosi_unexpected", 1, 0);
                        else check("mosi_word", int'(mo), int'(exp_tx.pop_front()));
                        if (!rx_fifo_full) exp_rx.push_back(mi);
                        else exp_ovf = 1'b1;
                    end
                end else if (!spi_sck && sck_prev) begin
                    check("sck_high_len", run, DIV);
                    run = 1;
                    since_fall = 0;
                end else begin
                    run++;
                    since_fall++;
                end
                if (spi_cs_n && !cs_prev) begin
                    check("cs_release", since_fall, DIV + 1);
                    last_win = win;
                    win = 0;
                end
                if (spi_cs_n && spi_sck) check("sck_without_cs", 1, 0);
                sck_prev = spi_sck;
                cs_prev  = spi_cs_n;
            end
            miso_rand = 1'($urandom);
        end
    end

    // RX monitor: every write strobe must carry the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_fifo_wr) begin
                wr_count++;
                if (rx_fifo_full) check("wr_while_full", 1, 0);
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_word", int'(rx_fifo_din), int'(exp_rx.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] w);
        txq.push_back(w);
        tx_fifo_empty = 1'b0;
    endtask

    task automatic wait_idle();
        int done = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && (!enable || txq.size() == 0)) begin
                done = 1;
                break;
            end
        end
        check("idle_reached", done, 1);
        drive_edge();
    endtask

    task automatic wait_pulses(input int n);
        int target = pulses_total + n;
        int done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pulses_total >= target) begin
                done = 1;
                break;
            end
        end
        check("pulses_reached", done, 1);
    endtask

    initial begin
        int rd0, wr0, hi;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_rd", tx_fifo_rd, 0);
        check("rst_wr", rx_fifo_wr, 0);
        check("rst_din", int'(rx_fifo_din), 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", rx_overflow, 0);
        #1 rst = 1'b0;

        // Enabled with nothing to send.
        drive_edge();
        enable = 1'b1;
        rd0 = rd_count;
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || !spi_cs_n || tx_fifo_rd) hi++;
        end
        check("empty_idle_activity", hi, 0);
        check("empty_rd_count", rd_count - rd0, 0);

        // Single looped-back word.
        drive_edge();
        rd0 = rd_count; wr0 = wr_count;
        push(8'hA5);
        wait_idle();
        check("single_rd", rd_count - rd0, 1);
        check("single_wr", wr_count - wr0, 1);
        check("single_pulses", last_win, W);

        // Two-word burst under one CS window.
        rd0 = rd_count; wr0 = wr_count;
        push(8'h3C);
        push(8'hC3);
        wait_idle();
        check("burst_rd", rd_count - rd0, 2);
        check("burst_wr", wr_count - wr0, 2);
        check("burst_pulses", last_win, 2 * W);

        // Enable dropped mid-word: the word completes, the next one stays queued.
        rd0 = rd_count; wr0 = wr_count;
        push(8'h96);
        push(8'h69);
        wait_pulses(3);
        drive_edge();
        enable = 1'b0;
        wait_idle();
        check("drop_rd", rd_count - rd0, 1);
        check("drop_wr", wr_count - wr0, 1);
        check("drop_pulses", last_win, W);
        check("drop_left", txq.size(), 1);
        enable = 1'b1;
        wait_idle();
        check("drop_drain_rd", rd_count - rd0, 2);

        // Reset in the middle of a word.
        wr0 = wr_count;
        push(8'h5A);
        wait_pulses(4);
        drive_edge();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cs_n", spi_cs_n, 1);
        check("mid_rst_sck", spi_sck, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd", tx_fifo_rd, 0);
        #1;
        rst = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        exp_ovf = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_wr", wr_count - wr0, 0);
        drive_edge();
        rd0 = rd_count;
        push(8'hE1);
        wait_idle();
        check("post_rst_rd", rd_count - rd0, 1);
        check("post_rst_wr", wr_count - wr0, 1);

        // Overflow: the word is dropped and the flag stays set afterwards.
        wr0 = wr_count;
        rx_fifo_full = 1'b1;
        miso_mode = 1;
        push(8'h12);
        wait_idle();
        check("ovf_no_wr", wr_count - wr0, 0);
        check("ovf_flag", rx_overflow, 1);
        rx_fifo_full = 1'b0;
        miso_mode = 0;
        push(8'h34);
        wait_idle();
        check("ovf_next_wr", wr_count - wr0, 1);
        check("ovf_sticky", rx_overflow, 1);

        // Randomised batches with random MISO data and back-pressure.
        for (int it = 0; it < 25; it++) begin
            int n;
            n = $urandom_range(1, 3);
            rd0 = rd_count;
            miso_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            rx_fifo_full = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < n; k++) push(W'($urandom));
            wait_idle();
            check("rand_rd", rd_count - rd0, n);
            check("rand_pulses", last_win, n * W);
            check("rand_ovf", rx_overflow, int'(exp_ovf));
        end
        rx_fifo_full = 1'b0;
        repeat (5) @(negedge clk);
        check("rx_queue_drained", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
